// File: rtl/poisson_array_core.sv
// Time-multiplexed Poisson spike-source array sharing one evaluator.
// Each tick sweeps all neurons: read {activity, refractory}, compare against the
// shared LFSR, write refractory back and queue the address of spiking neurons.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CLEAR   | zeroing state memory one address per cycle, busy=1
// ST_IDLE    | waiting for tick, host writes land directly in memory
// ST_SWEEP   | two-stage read/evaluate pipeline walking addresses 0..N-1
module poisson_array_core #(
  parameter int              N_NEUR           = 64,
  parameter int              ACTIVITY_WIDTH   = 9,
  parameter int              REFRACTORY_WIDTH = 4,
  parameter int              DT_SHIFT         = 4,
  parameter logic [15:0]     LFSR_SEED        = 16'hACE1,
  parameter int              FIFO_DEPTH       = 8,
  localparam int             AW               = $clog2(N_NEUR)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [REFRACTORY_WIDTH-1:0] refr_per,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [ACTIVITY_WIDTH-1:0]   wr_activity,
  output logic                        spk_valid,
  input  logic                        spk_ready,
  output logic [AW-1:0]               spk_addr,
  output logic                        busy,
  output logic                        overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (ACTIVITY_WIDTH + DT_SHIFT > 16) ? ACTIVITY_WIDTH + DT_SHIFT : 16;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  localparam logic [AW-1:0]               A_ONE   = AW'(1);
  localparam logic [AW-1:0]               A_LAST  = AW'(N_NEUR - 1);
  localparam logic [PW-1:0]               P_ONE   = PW'(1);
  localparam logic [PW:0]                 C_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]                 C_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [REFRACTORY_WIDTH-1:0] R_ONE   = REFRACTORY_WIDTH'(1);

  logic [1:0]                  state;
  logic [AW-1:0]               clr_addr;
  logic [AW-1:0]               rd_addr;
  logic                        rd_done;
  logic [REFRACTORY_WIDTH-1:0] refr_lat;
  logic                        s1_valid;
  logic [AW-1:0]               s1_addr;
  logic [ACTIVITY_WIDTH-1:0]   s1_act;
  logic [REFRACTORY_WIDTH-1:0] s1_ref;
  logic [15:0]                 lfsr;

  logic [ACTIVITY_WIDTH-1:0]   act_mem [N_NEUR];
  logic [REFRACTORY_WIDTH-1:0] ref_mem [N_NEUR];

  logic [AW-1:0]               fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [PW:0]                 fifo_cnt;

  logic                        wr_ok;
  logic [CW-1:0]               scaled;
  logic [CW-1:0]               rnd_ext;
  logic                        cond;
  logic                        s1_spike;
  logic                        fifo_full;
  logic                        stall;
  logic                        wb_en;
  logic                        push;
  logic                        pop;
  logic [REFRACTORY_WIDTH-1:0] ref_new;
  logic [ACTIVITY_WIDTH-1:0]   rd_fwd_act;
  logic [15:0]                 lfsr_next;

  // Evaluator, stall and forwarding decisions for the current cycle
  always_comb begin
    wr_ok      = wr_en && (state != ST_CLEAR) && (32'(wr_addr) < N_NEUR);
    scaled     = CW'(s1_act) << DT_SHIFT;
    rnd_ext    = CW'(lfsr);
    cond       = scaled >= rnd_ext;
    s1_spike   = s1_valid && (s1_ref == '0) && cond;
    fifo_full  = (fifo_cnt == C_FULL);
    // Hold the whole pipeline only when a spike actually needs a free slot
    stall      = s1_spike && fifo_full;
    wb_en      = (state == ST_SWEEP) && !stall && s1_valid;
    push       = wb_en && s1_spike;
    pop        = spk_valid && spk_ready;
    if (s1_ref != '0)
      ref_new = s1_ref - R_ONE;
    else if (cond)
      ref_new = refr_lat;
    else
      ref_new = '0;
    rd_fwd_act = (wr_ok && (wr_addr == rd_addr)) ? wr_activity : act_mem[rd_addr];
    lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign spk_valid = (fifo_cnt != '0);
  assign spk_addr  = spk_valid ? fifo_mem[rd_ptr] : '0;
  assign busy      = (state != ST_IDLE);

  // Sequencer: clear walk, sweep pipeline, LFSR and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      rd_addr  <= '0;
      rd_done  <= 1'b0;
      refr_lat <= '0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_act   <= '0;
      s1_ref   <= '0;
      lfsr     <= LFSR_SEED;
      overrun  <= 1'b0;
    end else begin
      if (tick && (state != ST_IDLE))
        overrun <= 1'b1;
      if (wb_en)
        lfsr <= lfsr_next;
      case (state)
        ST_CLEAR: begin
          if (clr_addr == A_LAST)
            state <= ST_IDLE;
          else
            clr_addr <= clr_addr + A_ONE;
        end
        ST_IDLE: begin
          if (tick) begin
            state    <= ST_SWEEP;
            rd_addr  <= '0;
            rd_done  <= 1'b0;
            s1_valid <= 1'b0;
            refr_lat <= refr_per;
          end
        end
        ST_SWEEP: begin
          if (!stall) begin
            if (!rd_done) begin
              s1_valid <= 1'b1;
              s1_addr  <= rd_addr;
              s1_act   <= rd_fwd_act;
              s1_ref   <= ref_mem[rd_addr];
              if (rd_addr == A_LAST)
                rd_done <= 1'b1;
              else
                rd_addr <= rd_addr + A_ONE;
            end else begin
              s1_valid <= 1'b0;
            end
            if (s1_valid && (s1_addr == A_LAST))
              state <= ST_IDLE;
          end else if (wr_ok && (wr_addr == s1_addr)) begin
            // Neuron already read but held by a stall: keep the host value
            s1_act <= wr_activity;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // State memory: cleared in ST_CLEAR, activity from host, refractory from evaluator
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      act_mem[clr_addr] <= '0;
      ref_mem[clr_addr] <= '0;
    end else begin
      if (wr_ok)
        act_mem[wr_addr] <= wr_activity;
      if (wb_en)
        ref_mem[s1_addr] <= ref_new;
    end
  end

  // Spike FIFO storage
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= s1_addr;
  end

  // Spike FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + P_ONE;
      if (pop)
        rd_ptr <= rd_ptr + P_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + C_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - C_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
